pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Receive-side counterpart of the PWM line driver.
- During the active hsync window it measures the high-time of each incoming PWM period and recovers the 8-bit duty code that the transmitter encoded.
- Each recovered code goes out on a single-entry valid/ready output stage, with status flags for glitched input and overrun.
- Sits downstream of the PWM output pin / loopback, feeding the line-data sink.

Parameters:
- PERIOD, 256, clock cycles per PWM period (matches the 8-bit global counter wrap); legal range 2..256.
- DW, 8, width of the recovered duty code.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- hsync  input  1  line-active window; a rising edge starts period 0.
- pwm_in  input  1  PWM waveform to decode.
- data_out  output  DW  recovered duty code.
- glitch_out  output  1  qualifies data_out: more than one high pulse was seen in that period.
- data_valid  output  1  data_out/glitch_out hold a word.
- data_ready  input  1  sink accepts the word when data_valid && data_ready.
- overrun  output  1  sticky: a completed period was dropped because the holding register was full.
- busy  output  1  FSM in MEASURE.

Behaviour:
- Reset (rst=0, async): FSM=IDLE. data_out=0, glitch_out=0, data_valid=0, overrun=0, busy=0. Internal counters are 0 and hsync_d is 0.
- hsync_d is the registered previous hsync. A rising edge means hsync=1 && hsync_d=0.
- FSM states: IDLE, MEASURE.
- IDLE:
  - On a hsync rising edge: go to MEASURE, phase=0, width=0, pulses=0.
  - The pwm_in sample in that same cycle is sample 0 of the period.
- MEASURE:
  - Each cycle, the sample at phase k (k=0..PERIOD-1) is counted.
  - If pwm_in=1: width += 1, saturating at 2^DW-1. A 100% duty period with PERIOD=256 reports 255.
  - Rising edge of pwm_in relative to the previous sample: pulses += 1. Sample 0 being high counts as one pulse. pulses saturates at 2.
  - On phase=PERIOD-1 (end of period):
    - The result {width_final, pulses>1} is offered to the output stage on the next clock edge.
    - phase wraps to 0 and width/pulses clear.
    - If hsync is still 1, stay in MEASURE; the next period starts immediately with no gap.
  - If hsync=0 at any cycle before the end-of-period sample:
    - Abort. The partial period is discarded with no output and no overrun.
    - Go to IDLE.
    - A falling hsync in the same cycle as phase=PERIOD-1 still completes that period.
- Output stage:
  - Latency: data_valid rises on the clock edge after the end-of-period sample. Period 0 valid appears PERIOD cycles after the hsync rising-edge cycle.
  - The word is held stable while data_valid=1 && data_ready=0.
  - Handshake: data_valid clears on the cycle after acceptance, unless a new word loads on that same edge.
  - Simultaneous accept and new word: the new word loads and data_valid stays 1.
  - New word with data_valid=1 && data_ready=0: the new word is dropped, the old word is retained, and overrun is set to 1.
  - overrun clears only on reset.
- busy = (FSM==MEASURE).
- Reset mid-period: immediate return to reset values. The pending word is lost.

Optional Feature:
- Macro PWM_CAPTURE_SYNC_EN.
- Defined:
  - pwm_in and hsync each pass through a 2-flop synchronizer before all logic above.
  - All timing (edge detect, period phase, output latency) shifts by +2 cycles relative to the pins.
  - Reset clears the synchronizers to 0.
- Undefined:
  - Inputs are used directly and must already be synchronous to clk.
  - Latency is exactly as stated above.

Test Plan:
- Reset, then hsync rising at cycle T with pwm_in high for cycles T..T+19, low after -> data_valid at T+256, data_out=20, glitch_out=0, data_ready=1 accepts -> data_valid=0 at T+257.
- Continuous hsync for 3 periods, duties 0, 128, 255 (256 high cycles), ready held 1 -> three words 0, 128, 255 at T+256, T+512, T+768; overrun=0.
- pwm_in high for cycles 0..9 and 50..59 of a period -> data_out=20, glitch_out=1.
- data_ready=0 through two completed periods (duties 20 then 40) -> data_out stays 20, overrun=1 at T+513; then ready=1 -> accepts 20, data_valid=0 on the next cycle.
- hsync falls at phase 100 -> no data_valid, FSM IDLE, busy=0. hsync falls exactly at phase 255 -> word delivered. rst=0 pulse mid-period -> all outputs 0 asynchronously.
- With PWM_CAPTURE_SYNC_EN defined, repeat scenario 1 -> data_valid at T+258, data_out=20.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM duty-code receiver: measures high time per PWM period inside the hsync window, single-entry valid/ready output.
// Optional PWM_CAPTURE_SYNC_EN adds 2-flop synchronizers on hsync and pwm_in (+2 cycles latency).
`timescale 1ns/1ps
module pwm_capture #(
    parameter int PERIOD = 256,
    parameter int DW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hsync,
    input  logic          pwm_in,
    output logic [DW-1:0] data_out,
    output logic          glitch_out,
    output logic          data_valid,
    input  logic          data_ready,
    output logic          overrun,
    output logic          busy
);

    localparam int PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);

    typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

    logic hsync_s;
    logic pwm_s;

`ifdef PWM_CAPTURE_SYNC_EN
    logic [1:0] hsync_sync_q, hsync_sync_d;
    logic [1:0] pwm_sync_q, pwm_sync_d;

    always_comb begin
        hsync_sync_d = {hsync_sync_q[0], hsync};
        pwm_sync_d   = {pwm_sync_q[0], pwm_in};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync_sync_q <= '0;
            pwm_sync_q   <= '0;
        end else begin
            hsync_sync_q <= hsync_sync_d;
            pwm_sync_q   <= pwm_sync_d;
        end
    end

    assign hsync_s = hsync_sync_q[1];
    assign pwm_s   = pwm_sync_q[1];
`else
    assign hsync_s = hsync;
    assign pwm_s   = pwm_in;
`endif

    state_t        state_q, state_d;
    logic          hsync_prev_q, hsync_prev_d;
    logic          pwm_prev_q, pwm_prev_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [DW-1:0] width_q, width_d;
    logic [1:0]    pulses_q, pulses_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_glitch_q, out_glitch_d;
    logic          out_valid_q, out_valid_d;
    logic          overrun_q, overrun_d;

    logic          hsync_rise;
    logic [PW-1:0] cur_phase;
    logic [DW-1:0] cur_width, width_inc;
    logic [1:0]    cur_pulses, pulses_inc;
    logic          prev_eff;
    logic          sample_en;
    logic          period_end;

    // In IDLE the rising-edge cycle is itself sample 0, so counters are
    // viewed as zero there rather than waiting a cycle to clear them.
    always_comb begin
        hsync_rise = hsync_s & ~hsync_prev_q;
        cur_phase  = (state_q == MEASURE) ? phase_q  : '0;
        cur_width  = (state_q == MEASURE) ? width_q  : '0;
        cur_pulses = (state_q == MEASURE) ? pulses_q : '0;
        prev_eff   = (cur_phase == '0) ? 1'b0 : pwm_prev_q;
        sample_en  = (state_q == IDLE) ? hsync_rise : (hsync_s || (cur_phase == LAST));
        period_end = sample_en && (cur_phase == LAST);
        width_inc  = (pwm_s && (cur_width != '1)) ? cur_width + DW'(1) : cur_width;
        pulses_inc = (pwm_s && !prev_eff && (cur_pulses != 2'd2)) ? cur_pulses + 2'd1 : cur_pulses;

        hsync_prev_d = hsync_s;
        pwm_prev_d   = pwm_s;
        phase_d      = '0;
        width_d      = '0;
        pulses_d     = '0;
        if (sample_en && !period_end) begin
            phase_d  = cur_phase + PW'(1);
            width_d  = width_inc;
            pulses_d = pulses_inc;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hsync_rise) state_d = MEASURE;
            end
            MEASURE: begin
                if (!sample_en || (period_end && !hsync_s)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == MEASURE);
    end

    // Output handshake: a word transfers on any edge where data_valid && data_ready;
    // the word is held while data_valid && !data_ready, and a new word arriving then
    // is dropped and flagged in the sticky overrun bit.
    always_comb begin
        out_data_d   = out_data_q;
        out_glitch_d = out_glitch_q;
        out_valid_d  = out_valid_q;
        overrun_d    = overrun_q;
        if (period_end) begin
            if (!out_valid_q || data_ready) begin
                out_data_d   = width_inc;
                out_glitch_d = (pulses_inc > 2'd1);
                out_valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && data_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            hsync_prev_q <= 1'b0;
            pwm_prev_q   <= 1'b0;
            phase_q      <= '0;
            width_q      <= '0;
            pulses_q     <= '0;
            out_data_q   <= '0;
            out_glitch_q <= 1'b0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hsync_prev_q <= hsync_prev_d;
            pwm_prev_q   <= pwm_prev_d;
            phase_q      <= phase_d;
            width_q      <= width_d;
            pulses_q     <= pulses_d;
            out_data_q   <= out_data_d;
            out_glitch_q <= out_glitch_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = out_data_q;
    assign glitch_out = out_glitch_q;
    assign data_valid = out_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: cycle-stamped expectations checked at the falling edge.
// Honours PWM_CAPTURE_SYNC_EN by shifting expected output timing by two cycles.
`timescale 1ns/1ps
module tb_pwm_capture;

    localparam int PERIOD = 256;
    localparam int DW     = 8;
`ifdef PWM_CAPTURE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          hsync = 1'b0;
    logic          pwm_in = 1'b0;
    logic          data_ready = 1'b1;
    logic [DW-1:0] data_out;
    logic          glitch_out;
    logic          data_valid;
    logic          overrun;
    logic          busy;

    pwm_capture #(.PERIOD(PERIOD), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .hsync      (hsync),
        .pwm_in     (pwm_in),
        .data_out   (data_out),
        .glitch_out (glitch_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int            at;
        logic          valid;
        logic [DW-1:0] data;
        logic          glitch;
        string         tag;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic expect_word(input int at, input logic v, input logic [DW-1:0] d,
                               input logic g, input string tag);
        exp_t e;
        e.at = at; e.valid = v; e.data = d; e.glitch = g; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every expectation is checked in the cycle it is stamped with.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].at == cyc) begin
                check({exp_q[i].tag, "_valid"}, 32'(data_valid), 32'(exp_q[i].valid));
                if (exp_q[i].valid) begin
                    check({exp_q[i].tag, "_data"}, 32'(data_out), 32'(exp_q[i].data));
                    check({exp_q[i].tag, "_glitch"}, 32'(glitch_out), 32'(exp_q[i].glitch));
                end
                exp_q.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        hsync  = 1'b0;
        pwm_in = 1'b0;
        repeat (n) tick();
    endtask

    // One PWM period (or part of one): pwm high on phases [a0,a1) and [b0,b1);
    // hsync drops at phase fall_at (-1 = never) and driving stops there.
    task automatic drive(input int a0, input int a1, input int b0, input int b1,
                         input int fall_at, input int n, input bit push,
                         input logic [DW-1:0] d, input logic g, input string tag);
        int c0;
        c0 = cyc;
        if (push) expect_word(c0 + PERIOD + LAT, 1'b1, d, g, tag);
        for (int k = 0; k < n; k++) begin
            hsync  = !(fall_at >= 0 && k >= fall_at);
            pwm_in = (k >= a0 && k < a1) || (k >= b0 && k < b1);
            tick();
            if (k == fall_at) break;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},   32'(data_valid), 32'd0);
        check({tag, "_data"},    32'(data_out),   32'd0);
        check({tag, "_glitch"},  32'(glitch_out), 32'd0);
        check({tag, "_overrun"}, 32'(overrun),    32'd0);
        check({tag, "_busy"},    32'(busy),       32'd0);
    endtask

    int c0;

    initial begin
        // reset state
        repeat (3) tick();
        check_reset_outputs("rst");
        rst = 1'b1;
        idle(3);

        // single period, 20 high cycles, ready held high
        c0 = cyc;
        expect_word(c0 + PERIOD - 1 + LAT, 1'b0, '0, 1'b0, "s1_early");
        expect_word(c0 + PERIOD + 1 + LAT, 1'b0, '0, 1'b0, "s1_accepted");
        drive(0, 20, 0, 0, -1, PERIOD, 1'b1, 8'd20, 1'b0, "s1_word");
        idle(8);

        // three back-to-back periods: 0, 128, full-high saturating to 255
        drive(0, 0,   0, 0, -1, PERIOD, 1'b1, 8'd0,   1'b0, "s2_w0");
        drive(0, 128, 0, 0, -1, PERIOD, 1'b1, 8'd128, 1'b0, "s2_w1");
        drive(0, 256, 0, 0, -1, PERIOD, 1'b1, 8'd255, 1'b0, "s2_w2");
        idle(8);
        check("s2_overrun", 32'(overrun), 32'd0);
        check("s2_drained", 32'(data_valid), 32'd0);

        // two pulses in one period
        drive(0, 10, 50, 60, -1, PERIOD, 1'b1, 8'd20, 1'b1, "s3_glitch");
        idle(8);

        // sink stalled across two completed periods
        data_ready = 1'b0;
        c0 = cyc;
        drive(0, 20, 0, 0, -1, PERIOD, 1'b1, 8'd20, 1'b0, "s4_w0");
        check("s4_no_overrun_yet", 32'(overrun), 32'd0);
        drive(0, 40, 0, 0, -1, PERIOD, 1'b0, '0, 1'b0, "s4_w1");
        hsync  = 1'b0;
        pwm_in = 1'b0;
        for (int i = 0; i < 8 && cyc < c0 + 2 * PERIOD + LAT; i++) tick();
        check("s4_hold_valid", 32'(data_valid), 32'd1);
        check("s4_hold_data",  32'(data_out),   32'd20);
        check("s4_overrun",    32'(overrun),    32'd1);
        tick();
        check("s4_hold2_data",   32'(data_out), 32'd20);
        check("s4_overrun_next", 32'(overrun),  32'd1);
        data_ready = 1'b1;
        tick();
        check("s4_accept_valid",  32'(data_valid), 32'd0);
        check("s4_overrun_stick", 32'(overrun),    32'd1);
        idle(4);

        // hsync drops at phase 100: no word
        c0 = cyc;
        expect_word(c0 + PERIOD + LAT, 1'b0, '0, 1'b0, "s5_abort");
        drive(0, 50, 0, 0, 100, PERIOD, 1'b0, '0, 1'b0, "s5_abort");
        idle(PERIOD);
        check("s5_abort_busy",  32'(busy),       32'd0);
        check("s5_abort_valid", 32'(data_valid), 32'd0);

        // hsync drops exactly on the last sample: word still delivered
        drive(0, 30, 0, 0, PERIOD - 1, PERIOD, 1'b1, 8'd30, 1'b0, "s5_fall_last");
        idle(8);
        check("s5_fall_last_busy", 32'(busy), 32'd0);

        // asynchronous reset mid-period with a word pending
        data_ready = 1'b0;
        drive(0, 20, 0, 0, -1, PERIOD, 1'b1, 8'd20, 1'b0, "s6_pending");
        drive(0, 0, 0, 0, -1, 100, 1'b0, '0, 1'b0, "s6_partial");
        repeat (LAT) tick();
        check("s6_busy_mid",   32'(busy),       32'd1);
        check("s6_pend_valid", 32'(data_valid), 32'd1);
        check("s6_pend_data",  32'(data_out),   32'd20);
        #1 rst = 1'b0;
        #1;
        check_reset_outputs("s6_async_rst");
        tick();
        hsync      = 1'b0;
        pwm_in     = 1'b0;
        data_ready = 1'b1;
        rst        = 1'b1;
        idle(5);
        check_reset_outputs("s6_after_rst");

        foreach (exp_q[i]) begin
            total++;
            bad++;
            $display("FAIL %s: expectation for cycle %0d never reached", exp_q[i].tag, exp_q[i].at);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
